// File: rtl/ipml_prefetch_fifo_sync_v2.sv
// ipml_prefetch_fifo_sync_v2: single-clock FWFT FIFO with water level, thresholds, error pulses and flush
module ipml_prefetch_fifo_sync_v2 #(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_OUTPUT_REG       = 0,
    parameter int c_ALMOST_FULL_NUM  = 2**c_DEPTH_WIDTH - 2,
    parameter int c_ALMOST_EMPTY_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_vld,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     wr_ovf,
    output logic                     rd_unf
);

    localparam int DW = c_DEPTH_WIDTH;
    localparam int W = c_DATA_WIDTH;
    localparam int L = (c_OUTPUT_REG != 0) ? 2 : 1;
    localparam int CAP_N = 1 << DW;
    localparam logic [DW:0] CAP = {1'b1, {DW{1'b0}}};
    localparam logic [DW:0] AF = c_ALMOST_FULL_NUM[DW:0];
    localparam logic [DW:0] AE = c_ALMOST_EMPTY_NUM[DW:0];
    localparam logic [2:0] PF_DEPTH = 3'(L + 1);

    logic [W-1:0]  mem [0:CAP_N-1];
    logic [W-1:0]  ram_dout;
    logic [W-1:0]  ram_out;
    logic [DW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, lvl_q, lvl_d;
    logic [L-1:0]  vld_q, vld_d;
    logic [W-1:0]  pf_q [0:L];
    logic [W-1:0]  pf_d [0:L];
    logic [1:0]    pf_cnt_q, pf_cnt_d, infl, wix;
    logic [2:0]    occ;
    logic          wr_acc, pop, issue, arrive;
    logic          wr_ovf_q, wr_ovf_d, rd_unf_q, rd_unf_d;

    assign wr_vld       = lvl_q != CAP;
    assign rd_vld       = pf_cnt_q != 2'd0;
    assign rd_data      = pf_q[0];
    assign water_level  = lvl_q;
    assign almost_full  = lvl_q >= AF;
    assign almost_empty = lvl_q <= AE;
    assign wr_ovf       = wr_ovf_q;
    assign rd_unf       = rd_unf_q;
    assign wr_acc       = wr_en & wr_vld & ~flush;
    assign pop          = rd_en & rd_vld & ~flush;
    assign arrive       = vld_q[L-1];

    // Pointers, level, read issue and in-flight tracking; occupancy counts the pending pop so reads keep pace
    always_comb begin
        infl = '0;
        for (int i = 0; i < L; i++) infl = infl + {1'b0, vld_q[i]};
        occ = {1'b0, pf_cnt_q} + {1'b0, infl} - {2'b0, pop};
        issue = ~flush & (wr_ptr_q != rd_ptr_q) & (occ < PF_DEPTH);
        vld_d = '0;
        if (!flush) begin
            vld_d[0] = issue;
            for (int i = 1; i < L; i++) vld_d[i] = vld_q[i-1];
        end
        wr_ptr_d = flush ? '0 : wr_ptr_q + {{DW{1'b0}}, wr_acc};
        rd_ptr_d = flush ? '0 : rd_ptr_q + {{DW{1'b0}}, issue};
        lvl_d = flush ? '0 : lvl_q + {{DW{1'b0}}, wr_acc} - {{DW{1'b0}}, pop};
        wr_ovf_d = ~flush & wr_en & ~wr_vld;
        rd_unf_d = ~flush & rd_en & ~rd_vld;
    end

    // Prefetch buffer: shift out on pop, land returning RAM word behind the remaining entries
    always_comb begin
        wix = pf_cnt_q - {1'b0, pop};
        pf_cnt_d = flush ? 2'd0 : wix + {1'b0, arrive};
        for (int i = 0; i <= L; i++) pf_d[i] = pf_q[i];
        if (pop) begin
            for (int i = 0; i < L; i++) pf_d[i] = pf_q[i+1];
            pf_d[L] = '0;
        end
        for (int i = 0; i <= L; i++) if (arrive && wix == 2'(i)) pf_d[i] = ram_out;
        if (flush) for (int i = 0; i <= L; i++) pf_d[i] = '0;
    end

    // Control and prefetch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            vld_q    <= '0;
            pf_cnt_q <= '0;
            wr_ovf_q <= 1'b0;
            rd_unf_q <= 1'b0;
            for (int i = 0; i <= L; i++) pf_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            vld_q    <= vld_d;
            pf_cnt_q <= pf_cnt_d;
            wr_ovf_q <= wr_ovf_d;
            rd_unf_q <= rd_unf_d;
            pf_q     <= pf_d;
        end
    end

    // Simple dual-port RAM with registered read; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[DW-1:0]] <= wr_data;
        if (issue) ram_dout <= mem[rd_ptr_q[DW-1:0]];
    end

    generate
        if (c_OUTPUT_REG != 0) begin : g_oreg
            logic [W-1:0] ram_pipe;
            // Optional RAM output register adding one cycle of read latency
            always_ff @(posedge clk) ram_pipe <= ram_dout;
            assign ram_out = ram_pipe;
        end else begin : g_noreg
            assign ram_out = ram_dout;
        end
    endgenerate

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_v2.sv
// tb_ipml_prefetch_fifo_sync_v2: directed checks of both RAM latencies side by side with shared stimulus
module tb_ipml_prefetch_fifo_sync_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data [2];
    logic [4:0]  wl [2];
    logic        rd_vld [2];
    logic        wr_vld [2];
    logic        af [2];
    logic        ae [2];
    logic        ovf [2];
    logic        unf [2];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ipml_prefetch_fifo_sync_v2 #(.c_DATA_WIDTH(16), .c_DEPTH_WIDTH(4), .c_OUTPUT_REG(0),
        .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_l1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .wr_vld(wr_vld[0]), .rd_data(rd_data[0]), .rd_en(rd_en), .rd_vld(rd_vld[0]),
        .water_level(wl[0]), .almost_full(af[0]), .almost_empty(ae[0]),
        .wr_ovf(ovf[0]), .rd_unf(unf[0]));

    ipml_prefetch_fifo_sync_v2 #(.c_DATA_WIDTH(16), .c_DEPTH_WIDTH(4), .c_OUTPUT_REG(1),
        .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .wr_vld(wr_vld[1]), .rd_data(rd_data[1]), .rd_en(rd_en), .rd_vld(rd_vld[1]),
        .water_level(wl[1]), .almost_full(af[1]), .almost_empty(ae[1]),
        .wr_ovf(ovf[1]), .rd_unf(unf[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string t(input string s, input int k);
        return $sformatf("%s/L%0d", s, k + 1);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string s);
        for (int k = 0; k < 2; k++) begin
            chk(t({s, "_rd_data"}, k), rd_data[k], 0);
            chk(t({s, "_rd_vld"}, k), rd_vld[k], 0);
            chk(t({s, "_wr_vld"}, k), wr_vld[k], 1);
            chk(t({s, "_level"}, k), wl[k], 0);
            chk(t({s, "_af"}, k), af[k], 0);
            chk(t({s, "_ae"}, k), ae[k], 1);
            chk(t({s, "_ovf"}, k), ovf[k], 0);
            chk(t({s, "_unf"}, k), unf[k], 0);
        end
    endtask

    task automatic write_seq(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = 16'(base + i);
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        wr_en = 1'b1;
        wr_data = 16'hABCD;
        step();
        wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("lat_e0_vld", k), rd_vld[k], 0);
            chk(t("lat_e0_lvl", k), wl[k], 1);
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            for (int k = 0; k < 2; k++) chk(t($sformatf("lat_e%0d_vld", e), k), rd_vld[k], e >= k + 2);
        end
        repeat (2) step();
        for (int k = 0; k < 2; k++) begin
            chk(t("lat_hold_data", k), rd_data[k], 16'hABCD);
            chk(t("lat_hold_vld", k), rd_vld[k], 1);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("lat_pop_vld", k), rd_vld[k], 0);
            chk(t("lat_pop_lvl", k), wl[k], 0);
        end

        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            wr_data = 16'(i);
            step();
            for (int k = 0; k < 2; k++) begin
                chk(t($sformatf("fill%0d_lvl", i), k), wl[k], i);
                chk(t($sformatf("fill%0d_af", i), k), af[k], i >= 14);
                chk(t($sformatf("fill%0d_ae", i), k), ae[k], i <= 2);
                chk(t($sformatf("fill%0d_wr_vld", i), k), wr_vld[k], i != 16);
            end
        end
        wr_en = 1'b0;
        step();
        rd_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 2; k++) begin
                chk(t($sformatf("drain%0d_vld", j), k), rd_vld[k], 1);
                chk(t($sformatf("drain%0d_data", j), k), rd_data[k], j + 1);
                chk(t($sformatf("drain%0d_lvl", j), k), wl[k], 16 - j);
                chk(t($sformatf("drain%0d_ae", j), k), ae[k], (16 - j) <= 2);
            end
            step();
        end
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("drained_vld", k), rd_vld[k], 0);
            chk(t("drained_lvl", k), wl[k], 0);
            chk(t("drained_ae", k), ae[k], 1);
        end

        write_seq(16, 16'h101);
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 16'hDEAD;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("full_rw_lvl", k), wl[k], 15);
            chk(t("full_rw_ovf", k), ovf[k], 1);
            chk(t("full_rw_wr_vld", k), wr_vld[k], 1);
            chk(t("full_rw_data", k), rd_data[k], 16'h102);
        end
        step();
        for (int k = 0; k < 2; k++) chk(t("ovf_one_cycle", k), ovf[k], 0);
        rd_en = 1'b1;
        for (int j = 0; j < 15; j++) begin
            for (int k = 0; k < 2; k++) chk(t($sformatf("bnd_drain%0d", j), k), rd_data[k], 16'h102 + j);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk(t("bnd_empty_lvl", k), wl[k], 0);
            chk(t("bnd_empty_vld", k), rd_vld[k], 0);
        end
        step();
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("unf_pulse", k), unf[k], 1);
            chk(t("unf_lvl", k), wl[k], 0);
        end
        step();
        for (int k = 0; k < 2; k++) chk(t("unf_one_cycle", k), unf[k], 0);

        write_seq(8, 16'h200);
        repeat (3) step();
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            wr_data = 16'(16'h208 + n);
            for (int k = 0; k < 2; k++) begin
                chk(t($sformatf("strm%0d_vld", n), k), rd_vld[k], 1);
                chk(t($sformatf("strm%0d_data", n), k), rd_data[k], 16'h200 + n);
            end
            step();
            for (int k = 0; k < 2; k++) begin
                chk(t($sformatf("strm%0d_lvl", n), k), wl[k], 8);
                chk(t($sformatf("strm%0d_ovf", n), k), ovf[k], 0);
                chk(t($sformatf("strm%0d_unf", n), k), unf[k], 0);
            end
        end
        wr_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 2; k++) chk(t($sformatf("strm_tail%0d", j), k), rd_data[k], 16'h264 + j);
            step();
        end
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) chk(t("strm_end_lvl", k), wl[k], 0);

        write_seq(11, 16'h300);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) chk(t("pre_flush_lvl", k), wl[k], 10);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'h03FF;
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(t("flush_lvl", k), wl[k], 0);
            chk(t("flush_rd_vld", k), rd_vld[k], 0);
            chk(t("flush_wr_vld", k), wr_vld[k], 1);
            chk(t("flush_ovf", k), ovf[k], 0);
            chk(t("flush_ae", k), ae[k], 1);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                chk(t($sformatf("flush_stale%0d", j), k), rd_vld[k], 0);
                chk(t($sformatf("flush_lvl%0d", j), k), wl[k], 0);
            end
        end
        write_seq(1, 16'h5555);
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk(t("post_flush_vld", k), rd_vld[k], 1);
            chk(t("post_flush_data", k), rd_data[k], 16'h5555);
            chk(t("post_flush_lvl", k), wl[k], 1);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;

        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 16'(16'h400 + i);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk(t("burst_vld", k), rd_vld[k], 1);
            chk(t("burst_lvl", k), wl[k], 4);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        wr_en = 1'b0;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) chk(t("arst_after_lvl", k), wl[k], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
